// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: start/load/hold/stop requests in,
// registered count plus busy/done/zero status out.
interface countdown_timer_if #(
    parameter int WIDTH = 3
);
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             hold;
    logic             stop;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             zero;

    modport master (
        output start, load_val, hold, stop,
        input  count, busy, done, zero
    );

    modport slave (
        input  start, load_val, hold, stop,
        output count, busy, done, zero
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with hold/stop and a one-cycle done pulse.
// Define AUTO_RELOAD_EN to make DONE reload the last start value and keep running.
//
//  state  | meaning
//  IDLE   | waiting for start; count holds its last value
//  RUN    | counting down (or frozen by hold)
//  DONE   | one-cycle completion pulse, count is 0
module countdown_timer #(
    parameter int WIDTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    countdown_timer_if.slave    tif
);

`ifdef AUTO_RELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
`else
    localparam bit AUTO_RELOAD = 1'b0;
`endif

    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;

        case (state_q)
            S_IDLE: begin
                if (tif.start) begin
                    count_d  = tif.load_val;
                    reload_d = tif.load_val;
                    state_d  = (tif.load_val != CNT_ZERO) ? S_RUN : S_DONE;
                end
            end

            S_RUN: begin
                if (tif.stop) begin
                    state_d = S_IDLE;
                end else if (!tif.hold) begin
                    // count is never 0 in RUN; guard anyway so it cannot wrap
                    if (count_q == CNT_ONE || count_q == CNT_ZERO) begin
                        count_d = CNT_ZERO;
                        state_d = S_DONE;
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end
            end

            S_DONE: begin
                if (tif.stop) begin
                    state_d = S_IDLE;
                end else if (AUTO_RELOAD && reload_q != CNT_ZERO) begin
                    count_d = reload_q;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tif.count = count_q;
    assign tif.busy  = busy_q;
    assign tif.done  = done_q;
    assign tif.zero  = (count_q == CNT_ZERO);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a cycle model predicts each edge's outputs,
// a separate monitor pops and compares them; directed scenarios then random traffic.
module tb_countdown_timer;
    localparam int WIDTH = 3;

`ifdef AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DONE = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    countdown_timer_if #(.WIDTH(WIDTH)) tif ();

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .tif (tif)
    );

    typedef struct packed {
        logic [WIDTH-1:0] count;
        logic             busy;
        logic             done;
        logic             zero;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    int m_cnt   = 0;
    int m_rel   = 0;
    int m_phase = PH_IDLE;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, expv, $time);
        end
    endtask

    // Reference model: one step per rising edge, expectation queued for the monitor.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_cnt   = 0;
                m_rel   = 0;
                m_phase = PH_IDLE;
            end else begin
                case (m_phase)
                    PH_IDLE: if (tif.start) begin
                        m_cnt   = int'(tif.load_val);
                        m_rel   = m_cnt;
                        m_phase = (m_cnt > 0) ? PH_RUN : PH_DONE;
                    end
                    PH_RUN: begin
                        if (tif.stop) m_phase = PH_IDLE;
                        else if (!tif.hold) begin
                            m_cnt = m_cnt - 1;
                            if (m_cnt == 0) m_phase = PH_DONE;
                        end
                    end
                    default: begin
                        if (tif.stop) m_phase = PH_IDLE;
                        else if (AUTO && m_rel > 0) begin
                            m_cnt   = m_rel;
                            m_phase = PH_RUN;
                        end else m_phase = PH_IDLE;
                    end
                endcase
            end
            e.count = WIDTH'(m_cnt);
            e.busy  = (m_phase == PH_RUN);
            e.done  = (m_phase == PH_DONE);
            e.zero  = (m_cnt == 0);
            exp_q.push_back(e);
        end
    end

    // Monitor: the DUT presents a result every edge; sample 2 time units later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow actual=empty expected=entry t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("count", int'(tif.count), int'(e.count));
                chk("busy",  int'(tif.busy),  int'(e.busy));
                chk("done",  int'(tif.done),  int'(e.done));
                chk("zero",  int'(tif.zero),  int'(e.zero));
                chk("busy_done_excl", int'(tif.busy & tif.done), 0);
            end
        end
    end

    task automatic cyc(input bit s, input int lv, input bit h, input bit sp);
        @(negedge clk);
        tif.start    = s;
        tif.load_val = WIDTH'(lv);
        tif.hold     = h;
        tif.stop     = sp;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic async_reset_check(input string tag);
        #1;
        chk({tag, "_count"}, int'(tif.count), 0);
        chk({tag, "_busy"},  int'(tif.busy),  0);
        chk({tag, "_done"},  int'(tif.done),  0);
        chk({tag, "_zero"},  int'(tif.zero),  1);
    endtask

    initial begin
        tif.start    = 1'b0;
        tif.load_val = '0;
        tif.hold     = 1'b0;
        tif.stop     = 1'b0;

        #1 rst = 1'b1;
        async_reset_check("rst_init");
        repeat (2) @(negedge clk);
        // start presented together with reset release
        rst          = 1'b0;
        tif.start    = 1'b1;
        tif.load_val = WIDTH'(5);
        idle(8);

        cyc(1'b1, 0, 1'b0, 1'b0);               // zero load
        idle(3);

        cyc(1'b1, 4, 1'b0, 1'b0);               // hold at count 2, start ignored in RUN
        idle(2);
        repeat (3) cyc(1'b0, 0, 1'b1, 1'b0);
        cyc(1'b1, 6, 1'b0, 1'b0);
        idle(4);

        cyc(1'b1, 6, 1'b0, 1'b0);               // stop at count 3
        idle(3);
        cyc(1'b0, 0, 1'b0, 1'b1);
        idle(2);

        cyc(1'b1, 7, 1'b0, 1'b0);               // maximum load
        idle(10);

        cyc(1'b1, 7, 1'b0, 1'b0);               // reset mid-run at count 6
        idle(1);
        @(negedge clk);
        #1 rst = 1'b1;
        async_reset_check("rst_midrun");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2);

        cyc(1'b1, 1, 1'b0, 1'b0);               // stop while in DONE
        idle(1);
        cyc(1'b0, 0, 1'b0, 1'b1);
        idle(2);

        cyc(1'b1, 3, 1'b0, 1'b0);               // reload loop (or single pulse)
        idle(10);
        cyc(1'b0, 0, 1'b0, 1'b1);
        idle(5);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 4) == 0, int'($urandom_range(0, 7)),
                ($urandom % 5) == 0, ($urandom % 16) == 0);
        end
        cyc(1'b0, 0, 1'b0, 1'b1);
        idle(3);

        @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
